// File: rtl/paralelo_a_serial_com_pkg.sv
// paralelo_a_serial_com_pkg: shared state encoding and line symbols for the serializer and the receive-side deserializer.
package paralelo_a_serial_com_pkg;
    typedef enum logic {ST_SYNC = 1'b0, ST_LINK = 1'b1} state_e;
    localparam logic [7:0] PHY_COM  = 8'hBC;
    localparam logic [7:0] PHY_IDLE = 8'h7C;
endpackage

// File: rtl/paralelo_a_serial_com_if.sv
// paralelo_a_serial_com_if: byte handshake in, serial line and status out.
interface paralelo_a_serial_com_if;
    logic [7:0] in;
    logic       valid;
    logic       ready;
    logic       out;
    logic       active;
    logic       byte_start;
    modport master (output in, valid, input ready, out, active, byte_start);
    modport slave (input in, valid, output ready, out, active, byte_start);
endinterface

// File: rtl/paralelo_a_serial_com_shift_out8.sv
// paralelo_a_serial_com_shift_out8: 8-bit MSB-first shifter; reloads from load_i when last_o is high.
module paralelo_a_serial_com_shift_out8
    import paralelo_a_serial_com_pkg::*;
#(
    parameter logic [7:0] RESET_BYTE = PHY_COM
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic [7:0] load_i,
    output logic       last_o,
    output logic       out_o,
    output logic       byte_start_o
);
    logic [7:0] sr_q, sr_d;
    logic [2:0] bc_q, bc_d;

    assign last_o = bc_q == 3'd7;

    always_comb begin
        sr_d = last_o ? load_i : {sr_q[6:0], 1'b0};
        bc_d = bc_q + 3'd1;
    end

    always_ff @(posedge clk32f) begin
        if (reset) begin
            sr_q         <= RESET_BYTE;
            bc_q         <= 3'd0;
            out_o        <= 1'b0;
            byte_start_o <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bc_q         <= bc_d;
            out_o        <= sr_q[7];
            byte_start_o <= bc_q == 3'd0;
        end
    end
endmodule

// File: rtl/paralelo_a_serial_com.sv
// paralelo_a_serial_com: byte serializer with COM preamble and IDLE fill.
// Define PHY_TX_SKIP_EN to force a COM every SKIP_INTERVAL link slots.
module paralelo_a_serial_com
    import paralelo_a_serial_com_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL    = PHY_COM,
    parameter logic [7:0] IDLE_SYMBOL   = PHY_IDLE,
    parameter int         COM_COUNT     = 4,
    parameter int         SKIP_INTERVAL = 16
) (
    input  logic                   clk32f,
    input  logic                   reset,
    paralelo_a_serial_com_if.slave bus
);
    localparam int CW = $clog2(COM_COUNT + 1);

    if (COM_COUNT < 1 || SKIP_INTERVAL < 2) begin : g_bad_cfg
        $error("paralelo_a_serial_com: COM_COUNT must be >=1 and SKIP_INTERVAL >=2");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] com_cnt_q, com_cnt_d;
    logic          active_q;
    logic          last;
    logic          skip;
    logic          preamble_more;
    logic [7:0]    load;

    assign preamble_more = int'(com_cnt_q) + 1 < COM_COUNT;

`ifdef PHY_TX_SKIP_EN
    localparam int SW = $clog2(SKIP_INTERVAL);
    logic [SW-1:0] slot_q, slot_d;

    assign skip = state_q == ST_LINK && slot_q == SW'(SKIP_INTERVAL - 1);

    // Held at zero through SYNC so the count starts fresh on entering LINK.
    always_comb begin
        slot_d = (state_q == ST_SYNC || (skip && last)) ? '0 : last ? slot_q + 1'b1 : slot_q;
    end

    always_ff @(posedge clk32f) begin
        if (reset) slot_q <= '0;
        else       slot_q <= slot_d;
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            com_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            active_q  <= state_q == ST_LINK;
        end
    end

    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        if (state_q == ST_SYNC && last) begin
            com_cnt_d = com_cnt_q + 1'b1;
            state_d   = preamble_more ? ST_SYNC : ST_LINK;
        end
    end

    always_comb begin
        bus.ready = state_q == ST_LINK && last && !skip;
        load      = state_q == ST_SYNC ? (preamble_more ? COM_SYMBOL : IDLE_SYMBOL)
                  : skip               ? COM_SYMBOL
                  : bus.valid && bus.ready ? bus.in : IDLE_SYMBOL;
    end

    assign bus.active = active_q;

    paralelo_a_serial_com_shift_out8 #(.RESET_BYTE(COM_SYMBOL)) u_shift (
        .clk32f      (clk32f),
        .reset       (reset),
        .load_i      (load),
        .last_o      (last),
        .out_o       (bus.out),
        .byte_start_o(bus.byte_start)
    );
endmodule

// File: tb/tb_paralelo_a_serial_com.sv
// tb_paralelo_a_serial_com: directed bench with a byte scoreboard fed by the stimulus and drained by a serial monitor.
module tb_paralelo_a_serial_com;
    import paralelo_a_serial_com_pkg::*;

    localparam int COM_COUNT     = 4;
    localparam int SKIP_INTERVAL = 16;

    logic clk32f   = 1'b0;
    logic reset    = 1'b1;
    logic rst_seen = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   sync_k   = 0;
    int   link_n   = 0;
    int   bit_cnt  = 0;
    logic [7:0] sh = '0;
    logic [7:0] q[$];

    paralelo_a_serial_com_if bus ();

    paralelo_a_serial_com #(.COM_COUNT(COM_COUNT), .SKIP_INTERVAL(SKIP_INTERVAL)) dut (
        .clk32f(clk32f),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk32f = ~clk32f;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32f);
        #1;
    endtask

    // One 8-edge byte slot ending on the load edge; records the byte that edge loads.
    task automatic slot(input bit v, input logic [7:0] d, input int rise, output bit acc);
        bit link, skip;
        logic [7:0] e;
        link = sync_k >= COM_COUNT;
        skip = 1'b0;
`ifdef PHY_TX_SKIP_EN
        if (link) skip = (link_n + 1) % SKIP_INTERVAL == 0;
`endif
        bus.in = d;
        for (int i = 0; i < 8; i++) begin
            bus.valid = v && i >= rise;
            chk("ready", bus.ready, link && !skip && i == 7);
            if (i == 1) chk("active", bus.active, link);
            tick();
        end
        bus.valid = 1'b0;
        acc = link && !skip && v;
        if (!link) begin
            sync_k++;
            e = sync_k < COM_COUNT ? PHY_COM : PHY_IDLE;
        end else begin
            link_n++;
            e = skip ? PHY_COM : acc ? d : PHY_IDLE;
        end
        q.push_back(e);
    endtask

    task automatic restart();
        reset = 1'b0;
        sync_k = 0;
        link_n = 0;
        q.push_back(PHY_COM);
    endtask

    always @(posedge clk32f) rst_seen <= reset;

    always @(negedge clk32f) begin
        logic [7:0] e;
        if (rst_seen) begin
            bit_cnt = 0;
        end else begin
            chk("byte_start", bus.byte_start, bit_cnt == 0);
            sh = {sh[6:0], bus.out};
            bit_cnt++;
            if (bit_cnt == 8) begin
                bit_cnt = 0;
                e = 'x;
                if (q.size() != 0) e = q.pop_front();
                chk("byte", sh, e);
            end
        end
    end

    initial begin
        bit acc;
        logic [7:0] d;
        bus.in = '0;
        bus.valid = 1'b0;
        repeat (3) @(posedge clk32f);
        #1;
        chk("rst_out", bus.out, 1'b0);
        chk("rst_active", bus.active, 1'b0);
        chk("rst_byte_start", bus.byte_start, 1'b0);
        chk("rst_ready", bus.ready, 1'b0);
        restart();
        repeat (COM_COUNT) slot(1'b0, 8'h00, 0, acc);
        repeat (2) slot(1'b0, 8'h00, 0, acc);
        slot(1'b1, 8'hA5, 0, acc);
        slot(1'b0, 8'h00, 0, acc);
        slot(1'b1, 8'h01, 7, acc);
        slot(1'b1, 8'h02, 7, acc);
        slot(1'b1, 8'h03, 7, acc);
        slot(1'b0, 8'h00, 0, acc);
        slot(1'b1, 8'h5A, 3, acc);
        slot(1'b0, 8'h00, 0, acc);
        d = 8'h10;
        repeat (36) begin
            slot(1'b1, d, 0, acc);
            if (acc) d = d + 8'd1;
        end
        slot(1'b1, 8'hF0, 7, acc);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("abort_out", bus.out, 1'b0);
        chk("abort_byte_start", bus.byte_start, 1'b0);
        chk("abort_active", bus.active, 1'b0);
        q.delete();
        repeat (2) tick();
        restart();
        repeat (COM_COUNT) slot(1'b0, 8'h00, 0, acc);
        repeat (2) slot(1'b0, 8'h00, 0, acc);
        repeat (9) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
